// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares the single MIO port between instruction fetch and data access
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort bus waits after TIMEOUT_CYCLES and pulse bus_err.
module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              MIO_ready,
  output logic              cpu_stall,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              grant_if;
  logic              grant_d;
  logic              complete;
  logic              abort;
  logic              timeout_hit;
  logic              last_d;
  logic              owner_d;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // When both requesters wait, the one not served last goes first (D on a tie after reset).
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!if_req || !last_d)) begin
          grant_d   = 1'b1;
          state_nxt = DATA;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH, DATA: begin
        if (MIO_ready) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d    <= 1'b0;
      owner_d   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if (grant_d) begin
        owner_d   <= 1'b1;
        lat_we    <= d_we;
        lat_addr  <= d_addr;
        lat_wdata <= d_wdata;
      end else if (grant_if) begin
        owner_d  <= 1'b0;
        lat_we   <= 1'b0;
        lat_addr <= if_addr;
      end
      if (complete) begin
        last_d <= owner_d;
        if (!owner_d) begin
          if_rdata <= mem_rdata;
        end else if (!lat_we) begin
          d_rdata <= mem_rdata;
        end
      end else if (abort) begin
        last_d <= owner_d;
        if (!owner_d) begin
          if_rdata <= '0;
        end else begin
          d_rdata <= '0;
        end
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= abort;
      if (grant_if || grant_d) begin
        wait_cnt <= '0;
      end else if (mem_req && !MIO_ready) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  // Abort on the wait cycle that would bring the count to TIMEOUT_CYCLES.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err     = err;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
  assign bus_err        = 1'b0;
`endif

  assign mem_req   = (state == FETCH) || (state == DATA);
  assign mem_we    = (state == DATA) && lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign if_ready  = (state == DONE) && !owner_d;
  assign d_ready   = (state == DONE) && owner_d;
  assign cpu_stall = (if_req || d_req) && !(if_ready || d_ready);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed bench with a transaction-level arbiter model checked every cycle
module tb_mem_bus_arbiter;

  localparam int          AW = 32;
  localparam int          DW = 32;
  localparam int          TO = 4;
  localparam logic [31:0] C  = 32'hA5A5_0000;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int LOAD_WAITS = TO - 1;
`else
  localparam int LOAD_WAITS = 5;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          MIO_ready;
  logic          cpu_stall;
  logic          bus_err;

  int tests = 0;
  int fails = 0;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .MIO_ready(MIO_ready),
    .cpu_stall(cpu_stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Model: one outstanding transaction, then a single completion cycle before the port is free.
  bit        m_busy, m_owner_d, m_we, m_fin, m_fin_d, m_err, m_last_d;
  bit [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  int        m_waits;
  logic      pick_d;

  assign pick_d = d_req && !(if_req && m_last_d);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_owner_d <= 0; m_we <= 0; m_fin <= 0; m_fin_d <= 0;
      m_err <= 0; m_last_d <= 0; m_addr <= 0; m_wdata <= 0;
      m_if_rdata <= 0; m_d_rdata <= 0; m_waits <= 0;
    end else if (m_fin) begin
      m_fin <= 0;
      m_err <= 0;
    end else if (m_busy) begin
      if (MIO_ready) begin
        m_busy   <= 0;
        m_fin    <= 1;
        m_fin_d  <= m_owner_d;
        m_last_d <= m_owner_d;
        if (!m_owner_d) m_if_rdata <= mem_rdata;
        else if (!m_we) m_d_rdata <= mem_rdata;
      end else begin
`ifdef MEM_ARB_TIMEOUT_EN
        if (m_waits + 1 == TO) begin
          m_busy   <= 0;
          m_fin    <= 1;
          m_err    <= 1;
          m_fin_d  <= m_owner_d;
          m_last_d <= m_owner_d;
          if (!m_owner_d) m_if_rdata <= 0;
          else m_d_rdata <= 0;
        end
`endif
        m_waits <= m_waits + 1;
      end
    end else if (if_req || d_req) begin
      m_busy    <= 1;
      m_owner_d <= pick_d;
      m_addr    <= pick_d ? d_addr : if_addr;
      m_we      <= pick_d & d_we;
      m_wdata   <= d_wdata;
      m_waits   <= 0;
    end
  end

  always @(negedge clk) begin
    chk("mem_req", mem_req, m_busy);
    chk("mem_we", mem_we, m_busy & m_owner_d & m_we);
    if (m_busy) chk("mem_addr", mem_addr, m_addr);
    if (m_busy && m_we) chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_ready", if_ready, m_fin & !m_fin_d);
    chk("d_ready", d_ready, m_fin & m_fin_d);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_rdata", d_rdata, m_d_rdata);
    chk("cpu_stall", cpu_stall, (if_req | d_req) & !m_fin);
    chk("bus_err", bus_err, m_fin & m_err);
  end

  task automatic do_txn(input bit dreq, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int waits, input string tag, output int lat);
    int seen;
    bit done;
    step();
    if (dreq) begin
      d_req = 1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1; if_addr = addr;
    end
    mem_rdata = rd; MIO_ready = 0; seen = 0; lat = 0; done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      step();
      lat++;
      if (dreq ? d_ready : if_ready) begin
        done = 1;
      end else if (mem_req) begin
        if (seen == 0) begin
          chk({tag, "_addr"}, mem_addr, addr);
          chk({tag, "_we"}, mem_we, dreq & we);
          if (dreq && we) chk({tag, "_wdata"}, mem_wdata, wd);
        end
        seen++;
        MIO_ready = (seen > waits);
        if (dreq) d_addr = d_addr ^ 32'h0000_FFF0;
      end
    end
    chk({tag, "_done"}, done, 1);
    if_req = 0; d_req = 0; MIO_ready = 0;
  endtask

  task automatic both_txn(input bit exp_d_first, input string tag);
    int first, got, n_first, n_second;
    step();
    if_req = 1; if_addr = 32'h0000_0040;
    d_req = 1; d_we = 0; d_addr = 32'h0000_2000; MIO_ready = 0;
    first = -1; got = 0; n_first = 0; n_second = 0;
    for (int n = 0; n < 20 && got < 2; n++) begin
      step();
      if (d_ready) begin
        if (first < 0) first = 1;
        got++;
        d_req = 0;
      end
      if (if_ready) begin
        if (first < 0) first = 0;
        got++;
        if_req = 0;
      end
      if (got == 1 && n_first == 0) n_first = n;
      if (got == 2) n_second = n;
      MIO_ready = mem_req;
      mem_rdata = mem_addr ^ C;
    end
    chk({tag, "_order"}, first, exp_d_first);
    chk({tag, "_count"}, got, 2);
    chk({tag, "_gap"}, n_second - n_first, 3);
    if_req = 0; d_req = 0; MIO_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int stall_cnt;
    rst = 1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0; MIO_ready = 0;
    repeat (2) step();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    rst = 0;

    both_txn(1, "both_rst");
    chk("both_rst_d_rdata", d_rdata, 32'hA5A5_2000);
    chk("both_rst_if_rdata", if_rdata, 32'hA5A5_0040);

    do_txn(0, 0, 32'h0, 32'h0, 32'h0050_0093, 0, "fetch", lat);
    chk("fetch_lat", lat, 2);
    chk("fetch_rdata", if_rdata, 32'h0050_0093);

    do_txn(1, 1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h1234_5678, 0, "store", lat);
    chk("store_lat", lat, 2);
    chk("store_d_rdata_kept", d_rdata, 32'hA5A5_2000);

    both_txn(0, "both_lastd");

    do_txn(1, 0, 32'h0000_2400, 32'h0, 32'hCAFE_F00D, LOAD_WAITS, "load_wait", lat);
    chk("load_wait_lat", lat, LOAD_WAITS + 2);
    chk("load_wait_rdata", d_rdata, 32'hCAFE_F00D);

    step();
    d_req = 1; d_we = 0; d_addr = 32'h0000_3000; MIO_ready = 0;
    step();
    chk("rstmid_busy", mem_req, 1);
    #1 rst = 1;
    #1;
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_d_ready", d_ready, 0);
    step();
    chk("rstmid_d_ready_hold", d_ready, 0);
    d_req = 0; rst = 0;
    step();
    chk("rstmid_after_ready", d_ready, 0);
    chk("rstmid_after_req", mem_req, 0);
    chk("rstmid_d_rdata", d_rdata, 0);

    do_txn(0, 0, 32'h0000_0004, 32'h0, 32'h0000_0013, 0, "fetch2", lat);
    chk("fetch2_lat", lat, 2);
    chk("fetch2_rdata", if_rdata, 32'h0000_0013);

    step();
    if_req = 1; if_addr = 32'h0000_0080; mem_rdata = 32'h0BAD_0BAD; MIO_ready = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    begin
      bit done;
      done = 0; lat = 0;
      for (int n = 0; n < 20 && !done; n++) begin
        step();
        lat++;
        if (if_ready) begin
          done = 1;
          chk("to_bus_err", bus_err, 1);
          chk("to_if_rdata", if_rdata, 0);
        end
      end
      chk("to_done", done, 1);
      chk("to_lat", lat, TO + 1);
      if_req = 0;
    end
`else
    stall_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (cpu_stall && !if_ready) stall_cnt++;
    end
    chk("hang_stall", stall_cnt, 20);
    chk("hang_bus_err", bus_err, 0);
    MIO_ready = 1;
    step();
    chk("hang_release_ready", if_ready, 1);
    chk("hang_release_rdata", if_rdata, 32'h0BAD_0BAD);
    if_req = 0; MIO_ready = 0;
`endif
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
